// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: multi-word sequential adder that computes
// {cout, y} = a + b + cin over N*W bits using one shared N-bit adder,
// processing one N-bit word per clock, least-significant word first.
//
// Ports:
//   clk        single clock, all state updates on its rising edge
//   reset      synchronous active-high reset
//   in_valid   request present on a, b, cin (accepted only while in_ready)
//   in_ready   high in IDLE, block can take a request
//   a, b       N*W-bit unsigned operands
//   cin        carry into the least-significant word
//   out_valid  high in DONE, y and cout hold the finished result
//   out_ready  consumer takes the result (only meaningful in DONE)
//   y          registered N*W-bit sum
//   cout       registered carry out of the most-significant word
//   busy       high while words are being added (RUN)

// adder_N: plain N-bit adder with carry in and carry out.
module adder_N #(
    parameter int N = 8
) (
    output logic [N-1:0] sum,
    output logic         cout,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

module adder_seq_ctrl #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    input  logic           cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] y,
    output logic           cout,
    output logic           busy
);

    // Word counter is at least one bit wide so W=1 still has a legal index.
    localparam int KW = (W > 1) ? $clog2(W) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [KW-1:0]  k;
    logic           carry;
    logic [N*W-1:0] a_reg;
    logic [N*W-1:0] b_reg;

    logic [N-1:0]   a_word;
    logic [N-1:0]   b_word;
    logic [N-1:0]   sum_word;
    logic           carry_word;

    logic           accept;
    logic           last_word;

    assign accept    = (state == IDLE) && in_valid;
    assign last_word = (state == RUN) && (k == K_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_word) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decode straight from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == RUN);
        out_valid = (state == DONE);
    end

    // Word select for the shared adder: a one-hot compare on k rather than
    // a variable shift, so k can only ever pick one of the W real words.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int i = 0; i < W; i++) begin
            if (k == KW'(i)) begin
                a_word = a_reg[i*N +: N];
                b_word = b_reg[i*N +: N];
            end
        end
    end

    adder_N #(.N(N)) u_adder (
        .sum  (sum_word),
        .cout (carry_word),
        .a    (a_word),
        .b    (b_word),
        .cin  (carry)
    );

    // Datapath: operands are frozen on accept so later changes on a/b/cin
    // cannot leak into a running operation. Each RUN cycle writes one word
    // of y and ripples the carry into the next cycle. k returns to 0 after
    // the last word so it never points past W-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            k     <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            y     <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            k     <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < W; i++) begin
                if (k == KW'(i)) begin
                    y[i*N +: N] <= sum_word;
                end
            end
            carry <= carry_word;
            if (last_word) begin
                k    <= '0;
                cout <= carry_word;
            end else begin
                k    <= k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: self-checking bench for adder_seq_ctrl.
// Main instance N=8/W=2 is checked every cycle against a countdown model
// that predicts handshake flags and the arithmetic result a+b+cin.
// A N=4/W=2 instance runs a back-to-back operand sweep against a result
// scoreboard, and a N=8/W=1 instance covers the single-word case.
module tb_adder_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main instance, N=8 W=2.
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, y;

    // Sweep instance, N=4 W=2.
    logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [7:0] a4, b4, y4;

    // Single-word instance, N=8 W=1.
    logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
    logic [7:0] a1, b1, y1;

    adder_seq_ctrl #(.N(8), .W(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .cout(cout), .busy(busy)
    );

    adder_seq_ctrl #(.N(4), .W(2)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .y(y4), .cout(cout4), .busy(busy4)
    );

    adder_seq_ctrl #(.N(8), .W(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .y(y1), .cout(cout1), .busy(busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Main-instance model: idle / counting down W cycles / holding a result.
    bit          m_idle = 1'b1;
    int          m_left = 0;
    bit          m_done = 1'b0;
    bit          m_zero = 1'b1;
    logic [16:0] m_res  = '0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_idle = 1'b1;
            m_left = 0;
            m_done = 1'b0;
            m_zero = 1'b1;
            m_res  = '0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle = 1'b0;
                m_left = 2;
                m_zero = 1'b0;
                m_res  = {1'b0, a} + {1'b0, b} + 17'(cin);
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (m_done && out_ready) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end
    end

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("in_ready", 32'(in_ready), 32'(m_idle));
            checkOutput("busy", 32'(busy), 32'(m_left > 0));
            checkOutput("out_valid", 32'(out_valid), 32'(m_done));
            if (m_done) checkOutput("result", 32'({cout, y}), 32'(m_res));
            if (m_zero) checkOutput("cleared", 32'({cout, y}), 32'd0);
        end
    end

    // Sweep instance scoreboard: result value, accept-to-valid latency W,
    // and accept-to-ready-again spacing W+1.
    logic [8:0] q_exp[$];
    int         q_acc[$];
    int         last_acc  = 0;
    bit         have_last = 1'b0;
    bit         prev_v4   = 1'b0;
    bit         prev_r4   = 1'b1;

    always @(negedge clk) begin
        if (chk_en) begin
            if (out_valid4 && !prev_v4) begin
                if (q_exp.size() == 0) begin
                    checkOutput("sweep_unexpected_valid", 32'(out_valid4), 32'd0);
                end else begin
                    logic [8:0] e;
                    int         t;
                    e = q_exp.pop_front();
                    t = q_acc.pop_front();
                    checkOutput("sweep_sum", 32'({cout4, y4}), 32'(e));
                    checkOutput("sweep_latency", 32'(cyc - t), 32'd2);
                    last_acc  = t;
                    have_last = 1'b1;
                end
            end
            if (in_ready4 && !prev_r4 && have_last) begin
                checkOutput("sweep_spacing", 32'(cyc - last_acc), 32'd3);
                have_last = 1'b0;
            end
            prev_v4 = out_valid4;
            prev_r4 = in_ready4;
        end
    end

    task automatic waitReady();
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // One-cycle request pulse, then scramble the inputs so a design that
    // failed to capture them would produce a wrong result.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        waitReady();
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~av;
        b        = bv ^ 16'h5A5A;
        cin      = ~cv;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    logic [15:0] ta[4]  = '{16'h8000, 16'hFFFF, 16'h0F0F, 16'h00FF};
    logic [15:0] tb_[4] = '{16'h8000, 16'hFFFF, 16'hF0F0, 16'hFF01};
    logic        tc[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] ty[4]  = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic        to[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

    logic [7:0] sa[4] = '{8'hFF, 8'h7F, 8'h12, 8'hFF};
    logic [7:0] sb[4] = '{8'h01, 8'h80, 8'h34, 8'hFF};
    logic       sc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] sy[4] = '{8'h00, 8'h00, 8'h46, 8'hFF};
    logic       so[4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int  lat;
        int  n;
        bit  abort;

        reset = 1'b1;
        in_valid = 1'b0;  a = '0;  b = '0;  cin = 1'b0;  out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_y", 32'({cout, y}), 32'd0);

        $display("[TB] carry out of full word");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        waitValid(lat);
        checkOutput("lat_ffff", 32'(lat), 32'd2);
        checkOutput("y_ffff", 32'(y), 32'h0000);
        checkOutput("cout_ffff", 32'(cout), 32'd1);

        $display("[TB] inter-word carry");
        applyStimulus(16'h00FF, 16'h0000, 1'b1);
        waitValid(lat);
        checkOutput("lat_00ff", 32'(lat), 32'd2);
        checkOutput("y_00ff", 32'(y), 32'h0100);
        checkOutput("cout_00ff", 32'(cout), 32'd0);

        $display("[TB] back-pressure hold");
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        waitValid(lat);
        checkOutput("lat_hold", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_y", 32'(y), 32'h5555);
            checkOutput("hold_cout", 32'(cout), 32'd0);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            if (i == 2) begin
                a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("after_hs_in_ready", 32'(in_ready), 32'd1);
        checkOutput("after_hs_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("ignored_pulse_busy", 32'(busy), 32'd0);

        $display("[TB] directed table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ta[i], tb_[i], tc[i]);
            waitValid(lat);
            checkOutput("tbl_lat", 32'(lat), 32'd2);
            checkOutput("tbl_y", 32'(y), 32'(ty[i]));
            checkOutput("tbl_cout", 32'(cout), 32'(to[i]));
        end

        $display("[TB] reset during second word");
        applyStimulus(16'h00FF, 16'h0001, 1'b0);
        @(negedge clk);
        checkOutput("busy_k1", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_run_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_run_y", 32'({cout, y}), 32'd0);
        checkOutput("rst_run_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rst_run_no_valid", 32'(out_valid), 32'd0);
        end

        $display("[TB] reset while holding result");
        out_ready = 1'b0;
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        waitValid(lat);
        checkOutput("rst_done_valid", 32'(out_valid), 32'd1);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_done_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_done_y", 32'({cout, y}), 32'd0);

        $display("[TB] reset beats in_valid");
        reset = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        checkOutput("rst_prio_busy", 32'(busy), 32'd0);
        checkOutput("rst_prio_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("rst_prio_busy2", 32'(busy), 32'd0);

        $display("[TB] single-word instance");
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!in_ready1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            a1 = sa[i]; b1 = sb[i]; cin1 = sc[i]; in_valid1 = 1'b1;
            @(negedge clk);
            in_valid1 = 1'b0; a1 = ~sa[i]; b1 = 8'h00; cin1 = ~sc[i];
            lat = 0;
            while (!out_valid1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checkOutput("w1_lat", 32'(lat), 32'd1);
            checkOutput("w1_y", 32'(y1), 32'(sy[i]));
            checkOutput("w1_cout", 32'(cout1), 32'(so[i]));
        end

        $display("[TB] back-to-back operand sweep");
        abort = 1'b0;
        for (int ai = 0; ai < 256 && !abort; ai++) begin
            for (int j = 0; j < 32 && !abort; j++) begin
                n = 0;
                while (!in_ready4 && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                if (!in_ready4) begin
                    checkOutput("sweep_ready_timeout", 32'(in_ready4), 32'd1);
                    abort = 1'b1;
                end else begin
                    a4   = 8'(ai);
                    b4   = 8'(j * 8 + ai % 8);
                    cin4 = 1'((ai ^ j) & 1);
                    q_exp.push_back({1'b0, a4} + {1'b0, b4} + 9'(cin4));
                    q_acc.push_back(cyc + 1);
                    in_valid4 = 1'b1;
                    @(negedge clk);
                    a4 = ~a4;
                    b4 = ~b4;
                end
            end
        end
        in_valid4 = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("sweep_drain", 32'(q_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
